// File: rtl/approach_sequencer.sv
// Requester side of the runway allocator: queues arriving aircraft and negotiates
// each head entry through a req_en pulse whose falling edge triggers the allocator.
module approach_sequencer #(
    parameter int PTR_W     = 2,
    parameter int RETRY_GAP = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             arr_valid,
    input  logic [1:0]       arr_type,
    output logic             arr_ready,
    output logic [1:0]       req_type,
    output logic             req_en,
    input  logic [3:0]       grant_code,
    output logic             land_a,
    output logic             land_b,
    output logic [1:0]       land_type,
    output logic             bad_code,
    output logic [7:0]       hold_count,
    output logic [PTR_W:0]   queue_count
);
    localparam int DEPTH = 2 ** PTR_W;
    localparam int GAP_W = (RETRY_GAP > 1) ? $clog2(RETRY_GAP) : 1;
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(RETRY_GAP - 1);
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);
    localparam logic [3:0] CODE_A    = 4'b1010;
    localparam logic [3:0] CODE_B    = 4'b1011;
    localparam logic [3:0] CODE_HOLD = 4'b1101;

    typedef enum logic [1:0] {
        IDLE,
        ASSERT,
        RELEASE,
        HOLD
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       fifo_q [DEPTH];
    logic [1:0]       fifo_d [DEPTH];
    logic [PTR_W:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]   rd_ptr_q, rd_ptr_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic             req_en_q, req_en_d;
    logic [1:0]       req_type_q, req_type_d;
    logic             land_a_q, land_a_d;
    logic             land_b_q, land_b_d;
    logic [1:0]       land_type_q, land_type_d;
    logic             bad_code_q, bad_code_d;
    logic [7:0]       hold_count_q, hold_count_d;
    logic             push, pop;
    logic [1:0]       head;

    // Pointers carry one extra bit so full and empty are distinguishable.
    assign queue_count = wr_ptr_q - rd_ptr_q;
    assign arr_ready   = (queue_count != FULL_COUNT);
    assign head        = fifo_q[rd_ptr_q[PTR_W-1:0]];
    assign push        = arr_valid && arr_ready;

    always_comb begin
        state_d      = state_q;
        gap_d        = gap_q;
        req_en_d     = 1'b0;
        req_type_d   = req_type_q;
        land_a_d     = 1'b0;
        land_b_d     = 1'b0;
        land_type_d  = land_type_q;
        bad_code_d   = 1'b0;
        hold_count_d = hold_count_q;
        pop          = 1'b0;

        case (state_q)
            IDLE: begin
                if (queue_count != '0) begin
                    state_d    = ASSERT;
                    req_en_d   = 1'b1;
                    req_type_d = head;
                end
            end
            ASSERT: begin
                state_d = RELEASE;
            end
            RELEASE: begin
                // The allocator has settled by now; its answer decides the head's fate.
                case (grant_code)
                    CODE_A: begin
                        pop         = 1'b1;
                        land_a_d    = 1'b1;
                        land_type_d = head;
                        state_d     = IDLE;
                    end
                    CODE_B: begin
                        pop         = 1'b1;
                        land_b_d    = 1'b1;
                        land_type_d = head;
                        state_d     = IDLE;
                    end
                    CODE_HOLD: begin
                        if (hold_count_q != 8'hFF) begin
                            hold_count_d = hold_count_q + 8'd1;
                        end
                        gap_d   = GAP_LOAD;
                        state_d = HOLD;
                    end
                    default: begin
                        bad_code_d = 1'b1;
                        gap_d      = GAP_LOAD;
                        state_d    = HOLD;
                    end
                endcase
            end
            HOLD: begin
                if (gap_q == '0) begin
                    state_d    = ASSERT;
                    req_en_d   = 1'b1;
                    req_type_d = head;
                end else begin
                    gap_d = gap_q - 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        fifo_d = fifo_q;
        if (push) begin
            fifo_d[wr_ptr_q[PTR_W-1:0]] = arr_type;
        end
        wr_ptr_d = wr_ptr_q + {{PTR_W{1'b0}}, push};
        rd_ptr_d = rd_ptr_q + {{PTR_W{1'b0}}, pop};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            fifo_q       <= '{default: 2'b00};
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            gap_q        <= '0;
            req_en_q     <= 1'b0;
            req_type_q   <= 2'b00;
            land_a_q     <= 1'b0;
            land_b_q     <= 1'b0;
            land_type_q  <= 2'b00;
            bad_code_q   <= 1'b0;
            hold_count_q <= 8'd0;
        end else begin
            state_q      <= state_d;
            fifo_q       <= fifo_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            gap_q        <= gap_d;
            req_en_q     <= req_en_d;
            req_type_q   <= req_type_d;
            land_a_q     <= land_a_d;
            land_b_q     <= land_b_d;
            land_type_q  <= land_type_d;
            bad_code_q   <= bad_code_d;
            hold_count_q <= hold_count_d;
        end
    end

    assign req_en     = req_en_q;
    assign req_type   = req_type_q;
    assign land_a     = land_a_q;
    assign land_b     = land_b_q;
    assign land_type  = land_type_q;
    assign bad_code   = bad_code_q;
    assign hold_count = hold_count_q;

endmodule

// File: tb/tb_approach_sequencer.sv
// Scoreboard bench for approach_sequencer: an allocator model answers each request,
// queues the expected outcome, and a monitor compares it when the outcome cycle arrives.
module tb_approach_sequencer;
    localparam int PTR_W     = 2;
    localparam int RETRY_GAP = 4;
    localparam int DEPTH     = 1 << PTR_W;
    localparam logic [3:0] CODE_A    = 4'b1010;
    localparam logic [3:0] CODE_B    = 4'b1011;
    localparam logic [3:0] CODE_HOLD = 4'b1101;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           arr_valid = 1'b0;
    logic [1:0]     arr_type = 2'b00;
    logic           arr_ready;
    logic [1:0]     req_type;
    logic           req_en;
    logic [3:0]     grant_code = 4'b0000;
    logic           land_a;
    logic           land_b;
    logic [1:0]     land_type;
    logic           bad_code;
    logic [7:0]     hold_count;
    logic [PTR_W:0] queue_count;

    approach_sequencer #(.PTR_W(PTR_W), .RETRY_GAP(RETRY_GAP)) dut (
        .clk(clk), .rst_n(rst_n), .arr_valid(arr_valid), .arr_type(arr_type),
        .arr_ready(arr_ready), .req_type(req_type), .req_en(req_en),
        .grant_code(grant_code), .land_a(land_a), .land_b(land_b),
        .land_type(land_type), .bad_code(bad_code), .hold_count(hold_count),
        .queue_count(queue_count)
    );

    always #5 clk = ~clk;

    typedef enum int {K_A, K_B, K_HOLD, K_BAD} kind_t;
    typedef struct {
        kind_t      kind;
        logic [1:0] ltype;
        int         hcount;
    } exp_t;
    typedef enum int {M_IDLE, M_BUSY, M_RETRY} mode_t;

    int         vectors = 0;
    int         miscompares = 0;
    logic [1:0] m_q[$];
    exp_t       exp_q[$];
    logic [3:0] forced_q[$];
    int         m_hold = 0;
    bit         pend_pop = 1'b0;
    int         cyc = 0;
    mode_t      mode = M_IDLE;
    int         idle_from = 0;
    int         retry_at = 0;
    int         outcome_at = 0;
    int         prev_count = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic [1:0] atype);
        @(negedge clk);
        #1;
        arr_valid = valid;
        arr_type  = atype;
    endtask

    function automatic logic [3:0] randomCode();
        int r;
        logic [3:0] c;
        r = $urandom_range(0, 9);
        if (r < 4) return CODE_A;
        if (r < 7) return CODE_B;
        if (r < 9) return CODE_HOLD;
        do c = 4'($urandom_range(0, 15));
        while (c == CODE_A || c == CODE_B || c == CODE_HOLD);
        return c;
    endfunction

    // Reference FIFO: arrivals join the back when there is room, grants remove the front.
    always @(posedge clk) begin
        bit was_full;
        if (!rst_n) begin
            m_q.delete();
            pend_pop = 1'b0;
            m_hold   = 0;
        end else begin
            was_full = (m_q.size() == DEPTH);
            cyc++;
            if (pend_pop) begin
                if (m_q.size() > 0) m_q.delete(0);
                pend_pop = 1'b0;
            end
            if (arr_valid && !was_full) m_q.push_back(arr_type);
        end
    end

    // Allocator model: answers each falling edge of req_en and queues what the DUT must show.
    always @(negedge req_en) begin
        logic [3:0] code;
        exp_t e;
        if (rst_n) begin
            if (forced_q.size() > 0) code = forced_q.pop_front();
            else code = randomCode();
            grant_code = code;
            e.ltype = (m_q.size() > 0) ? m_q[0] : 2'b00;
            if (code == CODE_A) begin
                e.kind   = K_A;
                pend_pop = 1'b1;
            end else if (code == CODE_B) begin
                e.kind   = K_B;
                pend_pop = 1'b1;
            end else if (code == CODE_HOLD) begin
                e.kind = K_HOLD;
                if (m_hold < 255) m_hold++;
            end else begin
                e.kind = K_BAD;
            end
            e.hcount = m_hold;
            exp_q.push_back(e);
        end
    end

    // Monitor: occupancy and request timing every cycle, outcomes two cycles after each request.
    always @(negedge clk) begin
        bit         exp_req;
        exp_t       e;
        logic [2:0] exp_pulses;
        if (!rst_n) begin
            mode       = M_IDLE;
            prev_count = 0;
            idle_from  = cyc;
            exp_q.delete();
        end else begin
            checkOutput("queue_count", 32'(queue_count), 32'(m_q.size()));
            checkOutput("arr_ready", 32'(arr_ready), 32'(m_q.size() != DEPTH));
            case (mode)
                M_IDLE:  exp_req = (cyc - 1 >= idle_from) && (prev_count != 0);
                M_RETRY: exp_req = (cyc == retry_at);
                default: exp_req = 1'b0;
            endcase
            checkOutput("req_en", 32'(req_en), 32'(exp_req));

            if (mode == M_BUSY && cyc == outcome_at) begin
                if (exp_q.size() == 0) begin
                    checkOutput("outcome_expected", 32'(exp_q.size()), 32'd1);
                    mode      = M_IDLE;
                    idle_from = cyc;
                end else begin
                    e = exp_q.pop_front();
                    case (e.kind)
                        K_A:     exp_pulses = 3'b100;
                        K_B:     exp_pulses = 3'b010;
                        K_BAD:   exp_pulses = 3'b001;
                        default: exp_pulses = 3'b000;
                    endcase
                    checkOutput("landing_pulses", 32'({land_a, land_b, bad_code}), 32'(exp_pulses));
                    if (e.kind == K_A || e.kind == K_B)
                        checkOutput("land_type", 32'(land_type), 32'(e.ltype));
                    checkOutput("hold_count", 32'(hold_count), 32'(e.hcount));
                    if (e.kind == K_A || e.kind == K_B) begin
                        mode      = M_IDLE;
                        idle_from = cyc;
                    end else begin
                        mode     = M_RETRY;
                        retry_at = cyc + RETRY_GAP;
                    end
                end
            end else begin
                checkOutput("spurious_pulse", 32'({land_a, land_b, bad_code}), 32'd0);
            end

            if (req_en) begin
                checkOutput("req_queue_nonempty", 32'(m_q.size() > 0), 32'd1);
                if (m_q.size() > 0) checkOutput("req_type", 32'(req_type), 32'(m_q[0]));
                mode       = M_BUSY;
                outcome_at = cyc + 2;
            end
            prev_count = m_q.size();
        end
    end

    task automatic resetDut();
        rst_n = 1'b0;
        forced_q.delete();
        grant_code = 4'b0000;
        repeat (2) @(negedge clk);
        #1;
        checkOutput("rst_req_en", 32'(req_en), 32'd0);
        checkOutput("rst_req_type", 32'(req_type), 32'd0);
        checkOutput("rst_land_a", 32'(land_a), 32'd0);
        checkOutput("rst_land_b", 32'(land_b), 32'd0);
        checkOutput("rst_land_type", 32'(land_type), 32'd0);
        checkOutput("rst_bad_code", 32'(bad_code), 32'd0);
        checkOutput("rst_hold_count", 32'(hold_count), 32'd0);
        checkOutput("rst_queue_count", 32'(queue_count), 32'd0);
        checkOutput("rst_arr_ready", 32'(arr_ready), 32'd1);
        rst_n = 1'b1;
    endtask

    task automatic waitDrain(input int bound);
        int n;
        n = 0;
        applyStimulus(1'b0, 2'b00);
        while (!(m_q.size() == 0 && mode == M_IDLE && exp_q.size() == 0) && n < bound) begin
            applyStimulus(1'b0, 2'b00);
            n++;
        end
        if (n >= bound) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL drain_timeout at cycle %0d: queue %0d, pending %0d", cyc, m_q.size(), exp_q.size());
        end
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int n;
        resetDut();

        $display("[TB] single aircraft to runway A");
        forced_q.push_back(CODE_A);
        applyStimulus(1'b1, 2'b01);
        waitDrain(50);

        $display("[TB] fill and drain with alternating runways");
        forced_q = '{CODE_B, CODE_A, CODE_B, CODE_A};
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 2'(i));
        waitDrain(100);

        $display("[TB] hold twice then grant");
        forced_q = '{CODE_HOLD, CODE_HOLD, CODE_B};
        applyStimulus(1'b1, 2'b10);
        waitDrain(100);

        $display("[TB] arrivals against a full queue during hold");
        forced_q = '{CODE_HOLD, CODE_HOLD, CODE_A};
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 2'($urandom_range(0, 3)));
        for (int i = 0; i < 24; i++) applyStimulus(1'b1, 2'($urandom_range(0, 3)));
        waitDrain(400);

        $display("[TB] unrecognised grant code");
        forced_q = '{4'b0000, CODE_A};
        applyStimulus(1'b1, 2'b11);
        waitDrain(100);

        $display("[TB] asynchronous reset during a request");
        forced_q.push_back(CODE_HOLD);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 2'(i + 1));
        n = 0;
        applyStimulus(1'b0, 2'b00);
        while (!(req_en && m_q.size() == 3) && n < 50) begin
            applyStimulus(1'b0, 2'b00);
            n++;
        end
        checkOutput("retry_with_three_queued", 32'(req_en && m_q.size() == 3), 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("async_req_en_drop", 32'(req_en), 32'd0);
        checkOutput("async_queue_clear", 32'(queue_count), 32'd0);
        resetDut();
        for (int i = 0; i < 10; i++) applyStimulus(1'b0, 2'b00);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 500; i++)
            applyStimulus($urandom_range(0, 2) == 0, 2'($urandom_range(0, 3)));
        waitDrain(800);

        $display("[TB] hold counter saturation");
        for (int i = 0; i < 300; i++) forced_q.push_back(CODE_HOLD);
        forced_q.push_back(CODE_A);
        applyStimulus(1'b1, 2'b01);
        waitDrain(2500);
        checkOutput("hold_count_saturated", 32'(hold_count), 32'd255);
        checkOutput("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
